pipe_reg_chain: RTL and testbench

//  Parametrised WIDTH-bit, STAGES-deep register pipeline with valid/ready flow control per stage.

---
 rtl/pipe_reg_chain_pkg.sv | 13 +
 rtl/pipe_reg_chain_stage.sv | 46 ++++
 rtl/pipe_reg_chain.sv | 77 +++++++
 tb/tb_pipe_reg_chain.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and sizing helpers for the pipe_reg_chain register slice.
// Optional build macro PIPE_RESET_DATA_EN is consumed by pipe_reg_chain_stage.
package pipe_reg_chain_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_STAGES = 3;

    // Bits needed to count 0..stages held items.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One valid/data register of the pipeline with its load logic.
// Define PIPE_RESET_DATA_EN to also clear the data register on reset.
module pipe_reg_chain_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    logic dat_en;

    // Data only moves when a real item arrives, so bubbles never toggle it.
    assign dat_en = load & in_vld & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= in_vld;
        end
    end

`ifdef PIPE_RESET_DATA_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dat <= '0;
        end else if (dat_en) begin
            dat <= in_dat;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (dat_en) begin
            dat <= in_dat;
        end
    end
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// STAGES-deep, WIDTH-bit valid/ready register pipeline with bubble collapsing.
// Build macro PIPE_RESET_DATA_EN (see pipe_reg_chain_stage) adds data reset.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [WIDTH-1:0]                  in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [WIDTH-1:0]                  out_data_o,
    output logic [occ_width(STAGES)-1:0]      occupancy_o
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic              accept;
    logic              emit;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             stg_in_vld;
        logic [WIDTH-1:0] stg_in_dat;

        // Stage k can load if any slot at or after it is empty or the sink takes an item;
        // this is the unrolled form of rdy[k] = ~vld[k] | rdy[k+1].
        assign rdy[k] = out_ready_i | ~(&vld[STAGES-1:k]);

        if (k == 0) begin : g_head
            assign stg_in_vld = in_valid_i;
            assign stg_in_dat = in_data_i;
        end else begin : g_body
            assign stg_in_vld = vld[k-1];
            assign stg_in_dat = dat[k-1];
        end

        pipe_reg_chain_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .load   (rdy[k]),
            .in_vld (stg_in_vld),
            .in_dat (stg_in_dat),
            .vld    (vld[k]),
            .dat    (dat[k])
        );
    end

    assign in_ready_o  = rdy[0] & ~reset;
    assign out_valid_o = vld[STAGES-1];
    assign out_data_o  = dat[STAGES-1];
    assign occupancy_o = occ_q;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = vld[STAGES-1] & out_ready_i;

    // Occupancy only moves on an unpaired accept or emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else if (accept && !emit) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (emit && !accept) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=8, STAGES=3).
// Define PIPE_RESET_DATA_EN for both RTL and bench to check the data-reset build.
module tb_pipe_reg_chain;

    logic       clk;
    logic       reset;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic [1:0] occupancy_o;

    int errors = 0;
    int checks = 0;

    pipe_reg_chain #(.WIDTH(8), .STAGES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One posedge passes; inputs change and outputs are sampled on the negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        cyc();
        cyc();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", out_valid_o); end
        checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", occupancy_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", in_ready_o); end
`ifdef PIPE_RESET_DATA_EN
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 00", out_data_o); end
`endif
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b expected 1", in_ready_o); end
        cyc();
        checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL rst_ignored_input: got occ %0d expected 0", occupancy_o); end
    endtask

    task automatic test_back_to_back();
        logic       vin [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] din [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        logic       ev  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        logic [1:0] eo  [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 6; i++) begin
            drive(vin[i], din[i], 1'b1);
            checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", i, in_ready_o); end
            cyc();
            checks++; if (out_valid_o !== ev[i]) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected %0b", i, out_valid_o, ev[i]); end
            if (ev[i]) begin
                checks++; if (out_data_o !== ed[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, out_data_o, ed[i]); end
            end
            checks++; if (occupancy_o !== eo[i]) begin errors++; $display("FAIL b2b_occ[%0d]: got %0d expected %0d", i, occupancy_o, eo[i]); end
        end
    endtask

    task automatic test_fill();
        logic [7:0] din [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       er  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] eo  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, din[i], 1'b0);
            checks++; if (in_ready_o !== er[i]) begin errors++; $display("FAIL fill_ready[%0d]: got %0b expected %0b", i, in_ready_o, er[i]); end
            cyc();
            checks++; if (occupancy_o !== eo[i]) begin errors++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, occupancy_o, eo[i]); end
        end
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h11) begin errors++; $display("FAIL fill_head: got v=%0b d=%0h expected v=1 d=11", out_valid_o, out_data_o); end
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h11) begin errors++; $display("FAIL fill_hold: got v=%0b d=%0h expected v=1 d=11", out_valid_o, out_data_o); end
    endtask

    task automatic test_full_pass();
        logic [7:0] ed [3] = '{8'h33, 8'h44, 8'h00};
        logic       ev [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] eo [3] = '{2'd2, 2'd1, 2'd0};
        drive(1'b1, 8'h44, 1'b1);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready: got %0b expected 1", in_ready_o); end
        cyc();
        checks++; if (occupancy_o !== 2'd3) begin errors++; $display("FAIL full_occ: got %0d expected 3", occupancy_o); end
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h22) begin errors++; $display("FAIL full_next: got v=%0b d=%0h expected v=1 d=22", out_valid_o, out_data_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            cyc();
            checks++; if (out_valid_o !== ev[i]) begin errors++; $display("FAIL drain_valid[%0d]: got %0b expected %0b", i, out_valid_o, ev[i]); end
            if (ev[i]) begin
                checks++; if (out_data_o !== ed[i]) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, out_data_o, ed[i]); end
            end
            checks++; if (occupancy_o !== eo[i]) begin errors++; $display("FAIL drain_occ[%0d]: got %0d expected %0d", i, occupancy_o, eo[i]); end
        end
    endtask

    task automatic test_bubble_collapse();
        drive(1'b1, 8'hA5, 1'b0);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5) begin errors++; $display("FAIL bub_head: got v=%0b d=%0h expected v=1 d=a5", out_valid_o, out_data_o); end
        drive(1'b1, 8'h5A, 1'b0);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bub_ready: got %0b expected 1", in_ready_o); end
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL bub_occ: got %0d expected 2", occupancy_o); end
        checks++; if (out_data_o !== 8'hA5) begin errors++; $display("FAIL bub_stall_data: got %0h expected a5", out_data_o); end
        // 5A must already sit right behind the output slot to appear after one release edge.
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h5A) begin errors++; $display("FAIL bub_second: got v=%0b d=%0h expected v=1 d=5a", out_valid_o, out_data_o); end
        checks++; if (occupancy_o !== 2'd1) begin errors++; $display("FAIL bub_occ1: got %0d expected 1", occupancy_o); end
        cyc();
        checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL bub_empty: got v=%0b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 8'h66, 1'b0);
        cyc();
        drive(1'b1, 8'h77, 1'b0);
        cyc();
        checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL mrst_pre_occ: got %0d expected 2", occupancy_o); end
        reset = 1'b1;
        drive(1'b1, 8'h88, 1'b1);
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %0b expected 0", in_ready_o); end
        cyc();
        checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL mrst_clear: got v=%0b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
`ifdef PIPE_RESET_DATA_EN
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL mrst_data: got %0h expected 00", out_data_o); end
`endif
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_release_ready: got %0b expected 1", in_ready_o); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL mrst_stale[%0d]: got v=%0b occ=%0d expected v=0 occ=0", i, out_valid_o, occupancy_o); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_fill();
        test_full_pass();
        test_bubble_collapse();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
